// File: rtl/serial_word_aligner.sv
// serial_word_aligner: hunts for the K28.5 comma in an LSB-first bit stream, then re-assembles 10-bit symbols tagged with their frame slot.
// Optional saturating missed-comma counter on errCount, enabled by `ALIGN_ERR_COUNT_EN.
module serial_word_aligner #(
    parameter logic [9:0]  COMMA_NEG  = 10'h17C,
    parameter logic [9:0]  COMMA_POS  = 10'h283,
    parameter int unsigned VERIFY_CNT = 3,
    parameter int unsigned LOSS_CNT   = 4
) (
    input  logic        bitclk,
    input  logic        rst,
    input  logic        sigIn,
    output logic [9:0]  symOut,
    output logic        symValid,
    output logic [2:0]  slot,
    output logic        locked,
    output logic [15:0] errCount
);

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned MISS_W = 4;
    localparam int unsigned ERR_W  = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [SYM_W-1:0]    sr_q,        sr_d;
    logic [BIT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [SLOT_W-1:0]   slot_cnt_q,  slot_cnt_d;
    logic [SLOT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q,  miss_cnt_d;
    logic [SYM_W-1:0]    sym_q,       sym_d;
    logic                valid_q,     valid_d;
    logic [SLOT_W-1:0]   slot_q,      slot_d;
    logic                locked_q,    locked_d;

    logic is_comma;
    logic boundary;

    assign is_comma = (sr_q == COMMA_NEG) || (sr_q == COMMA_POS);
    assign boundary = (bit_cnt_q == BIT_W'(SYM_W - 1));

    always_ff @(posedge bitclk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            sym_q       <= '0;
            valid_q     <= 1'b0;
            slot_q      <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            sym_q       <= sym_d;
            valid_q     <= valid_d;
            slot_q      <= slot_d;
            locked_q    <= locked_d;
        end
    end

    // Next-state: HUNT aligns on any comma; VERIFY/LOCKED only inspect slot 0 at boundaries.
    always_comb begin
        state_d     = state_q;
        sr_d        = {sigIn, sr_q[SYM_W-1:1]};
        bit_cnt_d   = boundary ? '0 : bit_cnt_q + BIT_W'(1);
        slot_cnt_d  = slot_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        sym_d       = sym_q;
        valid_d     = 1'b0;
        slot_d      = slot_q;
        locked_d    = locked_q;

        case (state_q)
            HUNT: begin
                if (is_comma) begin
                    sym_d       = sr_q;
                    slot_d      = '0;
                    valid_d     = 1'b1;
                    bit_cnt_d   = '0;
                    slot_cnt_d  = SLOT_W'(1);
                    match_cnt_d = SLOT_W'(1);
                    if (VERIFY_CNT == 1) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d  = VERIFY;
                    end
                end
            end
            VERIFY, LOCKED: begin
                if (boundary) begin
                    sym_d      = sr_q;
                    slot_d     = slot_cnt_q;
                    valid_d    = 1'b1;
                    slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                    if (slot_cnt_q == '0) begin
                        if (state_q == VERIFY) begin
                            if (!is_comma) begin
                                state_d     = HUNT;
                                match_cnt_d = '0;
                            end else if (match_cnt_q + SLOT_W'(1) == SLOT_W'(VERIFY_CNT)) begin
                                state_d     = LOCKED;
                                locked_d    = 1'b1;
                                match_cnt_d = '0;
                            end else begin
                                match_cnt_d = match_cnt_q + SLOT_W'(1);
                            end
                        end else if (is_comma) begin
                            miss_cnt_d = '0;
                        end else if (miss_cnt_q + MISS_W'(1) == MISS_W'(LOSS_CNT)) begin
                            state_d    = HUNT;
                            locked_d   = 1'b0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

`ifdef ALIGN_ERR_COUNT_EN
    logic             err_inc;
    logic [ERR_W-1:0] err_q;

    // A slot-0 boundary without a comma is an error in both VERIFY and LOCKED.
    assign err_inc = boundary && (slot_cnt_q == '0) && !is_comma &&
                     ((state_q == VERIFY) || (state_q == LOCKED));

    always_ff @(posedge bitclk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign errCount = err_q;
`else
    assign errCount = '0;
`endif

    assign symOut   = sym_q;
    assign symValid = valid_q;
    assign slot     = slot_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_serial_word_aligner.sv
// tb_serial_word_aligner: randomized-data directed scenarios for serial_word_aligner, checked against a bit-stream reference model.
module tb_serial_word_aligner;

    localparam logic [9:0] K_NEG = 10'h17C;
    localparam logic [9:0] K_POS = 10'h283;
    localparam logic [9:0] D_ALT = 10'h2AA;
    localparam int         VCNT  = 3;
    localparam int         LCNT  = 4;

    logic        bitclk;
    logic        rst;
    logic        sigIn;
    logic [9:0]  symOut;
    logic        symValid;
    logic [2:0]  slot;
    logic        locked;
    logic [15:0] errCount;

    int n_assert;
    int n_fail;

    // Reference model: history of bits since reset plus the alignment decision state.
    logic       hist[$];
    int         m_k;
    int         m_mode;      // 0 hunt, 1 verify, 2 locked
    int         m_next;      // edge index of next symbol emission
    int         m_slot;
    int         m_match;
    int         m_miss;
    int         m_err;
    logic [9:0] e_sym;
    logic       e_valid;
    logic [2:0] e_slot;
    logic       e_locked;

    serial_word_aligner dut (
        .bitclk   (bitclk),
        .rst      (rst),
        .sigIn    (sigIn),
        .symOut   (symOut),
        .symValid (symValid),
        .slot     (slot),
        .locked   (locked),
        .errCount (errCount)
    );

    initial bitclk = 1'b0;
    always #5 bitclk = ~bitclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_err();
`ifdef ALIGN_ERR_COUNT_EN
        return (m_err > 65535) ? 16'hFFFF : 16'(m_err);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        hist.delete();
        m_k = 0; m_mode = 0; m_next = 0; m_slot = 0;
        m_match = 0; m_miss = 0; m_err = 0;
        e_sym = '0; e_valid = 1'b0; e_slot = '0; e_locked = 1'b0;
    endtask

    task automatic model_emit(input logic [9:0] w, input int s);
        e_sym   = w;
        e_slot  = 3'(s);
        e_valid = 1'b1;
    endtask

    // One rising edge: decisions use the 10 most recent bits before this edge.
    task automatic model_edge(input logic b);
        logic [9:0] w;
        logic       comma;
        int         n;
        w = '0;
        n = hist.size();
        for (int i = 0; i < 10; i++) begin
            if (n - 10 + i >= 0) w[i] = hist[n - 10 + i];
        end
        comma   = (w == K_NEG) || (w == K_POS);
        e_valid = 1'b0;
        if (m_mode == 0) begin
            if (comma) begin
                model_emit(w, 0);
                m_next  = m_k + 10;
                m_slot  = 1;
                m_match = 1;
                if (VCNT == 1) begin m_mode = 2; e_locked = 1'b1; end
                else m_mode = 1;
            end
        end else if (m_k == m_next) begin
            model_emit(w, m_slot);
            m_next = m_k + 10;
            if (m_slot == 0) begin
                if (m_mode == 1) begin
                    if (comma) begin
                        m_match++;
                        if (m_match == VCNT) begin m_mode = 2; e_locked = 1'b1; end
                    end else begin
                        m_mode = 0; m_match = 0; m_err++;
                    end
                end else if (comma) begin
                    m_miss = 0;
                end else begin
                    m_miss++;
                    m_err++;
                    if (m_miss == LCNT) begin m_mode = 0; e_locked = 1'b0; m_miss = 0; end
                end
            end
            m_slot = (m_slot + 1) % 8;
        end
        hist.push_back(b);
        m_k++;
    endtask

    task automatic step(input logic b);
        sigIn = b;
        @(posedge bitclk);
        model_edge(b);
        #1;
        chk("symValid", 16'(symValid), 16'(e_valid));
        chk("symOut",   16'(symOut),   16'(e_sym));
        chk("slot",     16'(slot),     16'(e_slot));
        chk("locked",   16'(locked),   16'(e_locked));
        chk("errCount", errCount,      exp_err());
    endtask

    // Random data with no run of 3 equal bits, so no spurious comma can form.
    function automatic logic [9:0] rand_data();
        logic [9:0] v;
        int         run;
        int         worst;
        do begin
            v = 10'($urandom);
            run = 1; worst = 1;
            for (int i = 1; i < 10; i++) begin
                run = (v[i] == v[i-1]) ? run + 1 : 1;
                if (run > worst) worst = run;
            end
        end while (worst >= 3);
        return v;
    endfunction

    task automatic send_bits(input logic [9:0] v, input int first, input int last);
        for (int i = first; i <= last; i++) step(v[i]);
    endtask

    task automatic send_sym(input logic [9:0] v);
        send_bits(v, 0, 9);
    endtask

    task automatic send_frame(input logic [9:0] s0);
        send_sym(s0);
        for (int i = 0; i < 7; i++) send_sym(rand_data());
    endtask

    task automatic send_junk();
        send_bits(rand_data(), 0, 6);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_symValid", 16'(symValid), 16'h0);
        chk("rst_symOut",   16'(symOut),   16'h0);
        chk("rst_slot",     16'(slot),     16'h0);
        chk("rst_locked",   16'(locked),   16'h0);
        chk("rst_errCount", errCount,      16'h0);
        @(negedge bitclk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [9:0] d;
        logic       seen_neg;
        logic       seen_pos;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        sigIn    = 1'b0;
        model_reset();
        @(posedge bitclk);
        #1;
        do_reset();

        // Lock-up on RD- commas, with first-strobe latency checked explicitly
        send_junk();
        send_sym(K_NEG);
        chk("first_strobe_early", 16'(symValid), 16'h0);
        d = rand_data();
        step(d[0]);
        chk("first_strobe_valid", 16'(symValid), 16'h1);
        chk("first_strobe_sym",   16'(symOut),   16'(K_NEG));
        chk("first_strobe_slot",  16'(slot),     16'h0);
        send_bits(d, 1, 9);
        for (int i = 0; i < 6; i++) send_sym(rand_data());
        send_frame(K_NEG);
        chk("verify_not_locked", 16'(locked), 16'h0);
        send_frame(K_NEG);
        chk("lock_after_3", 16'(locked), 16'h1);
        send_frame(K_NEG);

        // Mixed polarity commas
        do_reset();
        seen_neg = 1'b0;
        seen_pos = 1'b0;
        send_junk();
        for (int f = 0; f < 6; f++) begin
            send_sym((f % 2 == 0) ? K_NEG : K_POS);
            step(1'b0);
            if (symValid && slot == 3'd0 && symOut == K_NEG) seen_neg = 1'b1;
            if (symValid && slot == 3'd0 && symOut == K_POS) seen_pos = 1'b1;
            send_bits(10'h2AA, 1, 9);
            for (int i = 0; i < 6; i++) send_sym(rand_data());
        end
        chk("mixed_locked",   16'(locked),   16'h1);
        chk("mixed_seen_neg", 16'(seen_neg), 16'h1);
        chk("mixed_seen_pos", 16'(seen_pos), 16'h1);

        // Loss of lock after LOSS_CNT missing slot-0 commas
        for (int f = 0; f < 3; f++) send_frame(D_ALT);
        chk("loss_hold_locked", 16'(locked), 16'h1);
        send_sym(D_ALT);
        chk("loss_pre_edge", 16'(locked), 16'h1);
        step(1'b1);
        chk("loss_dropped",     16'(locked),   16'h0);
        chk("loss_last_strobe", 16'(symValid), 16'h1);
        send_bits(10'h155, 1, 9);
        for (int i = 0; i < 6; i++) send_sym(rand_data());
`ifdef ALIGN_ERR_COUNT_EN
        chk("loss_errcount", errCount, 16'd4);
`else
        chk("loss_errcount", errCount, 16'd0);
`endif
        send_frame(D_ALT);
        chk("loss_stays_hunt", 16'(locked), 16'h0);

        // Verify failure: one comma then a slot-0 non-comma
        do_reset();
        send_junk();
        send_frame(K_NEG);
        send_frame(rand_data());
        send_frame(D_ALT);
        chk("vfail_locked", 16'(locked), 16'h0);
`ifdef ALIGN_ERR_COUNT_EN
        chk("vfail_errcount", errCount, 16'd1);
`else
        chk("vfail_errcount", errCount, 16'd0);
`endif

        // Bit slip after lock: drop one bit, lose lock, re-lock to the new phase
        do_reset();
        send_junk();
        for (int f = 0; f < 4; f++) send_frame(K_NEG);
        chk("slip_pre_locked", 16'(locked), 16'h1);
        send_sym(K_NEG);
        send_bits(rand_data(), 1, 9);
        for (int i = 0; i < 6; i++) send_sym(rand_data());
        for (int f = 0; f < 9; f++) send_frame(K_NEG);
        chk("slip_relocked", 16'(locked), 16'h1);
        send_sym(K_NEG);
        step(1'b0);
        chk("slip_sym",  16'(symOut), 16'(K_NEG));
        chk("slip_slot", 16'(slot),   16'h0);
`ifdef ALIGN_ERR_COUNT_EN
        chk("slip_errcount", errCount, 16'd4);
`else
        chk("slip_errcount", errCount, 16'd0);
`endif

        // Asynchronous reset mid-symbol while locked
        send_bits(10'h155, 1, 9);
        send_sym(rand_data());
        send_bits(rand_data(), 0, 3);
        chk("arst_pre_locked", 16'(locked), 16'h1);
        do_reset();
        for (int i = 0; i < 3; i++) send_sym(rand_data());
        chk("arst_no_lock", 16'(locked), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
